// File: rtl/mem_access_seq.sv
// Purpose : sequences CPU memory transactions (read to MDR, write from MDR,
//           fetch to IR) over MAR/MDR/IR load/enable lines and memory strobes.
// Latency : read/fetch req->done 2 cycles, write 3 cycles, +1 per wait state.
// Backpressure: req is taken only in IDLE and dropped while busy (no queue);
//               mem_ready stalls ACCESS until it arrives or the wait budget runs out.
// Ports   : clk, rst_n (async, active low)
//           req, req_kind[1:0] - one-cycle request from the control FSM
//           mem_ready          - memory completion strobe
//           busy, done, err    - status; done/err are registered one-cycle pulses
//           ld_mar, oe_mar, ld_mdr, oe_mdr, ld_ir - datapath register controls
//           mem_rd, mem_wr     - memory strobes
module mem_access_seq #(
   parameter int WAIT_MAX = 7,
   parameter int CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [1:0] req_kind,
   input  logic       mem_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       ld_mar,
   output logic       oe_mar,
   output logic       ld_mdr,
   output logic       oe_mdr,
   output logic       ld_ir,
   output logic       mem_rd,
   output logic       mem_wr
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WDATA  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   localparam logic [1:0] K_READ  = 2'b00;
   localparam logic [1:0] K_WRITE = 2'b01;
   localparam logic [1:0] K_FETCH = 2'b10;
   localparam logic [1:0] K_RSVD  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       kind, kind_nxt;
   logic             done_nxt, err_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         kind  <= K_READ;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         kind  <= kind_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;        // counter only survives while ACCESS keeps waiting
      kind_nxt  = kind;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      busy      = 1'b1;
      ld_mar    = 1'b0;
      oe_mar    = 1'b0;
      ld_mdr    = 1'b0;
      oe_mdr    = 1'b0;
      ld_ir     = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;

      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (req) begin
               if (req_kind == K_RSVD) begin
                  // reserved kind: no bus activity, just flag it
                  err_nxt = 1'b1;
               end else begin
                  // requester has the address on result_bus this cycle
                  ld_mar    = 1'b1;
                  kind_nxt  = req_kind;
                  state_nxt = (req_kind == K_WRITE) ? S_WDATA : S_ACCESS;
               end
            end
         end

         S_WDATA: begin
            // write data is on result_bus this cycle
            ld_mdr    = 1'b1;
            state_nxt = S_ACCESS;
         end

         S_ACCESS: begin
            oe_mar = 1'b1;
            if (kind == K_WRITE) begin
               mem_wr = 1'b1;
               oe_mdr = 1'b1;
            end else begin
               mem_rd = 1'b1;
            end
            // ready is checked first so it wins over a same-cycle timeout
            if (mem_ready) begin
               ld_mdr    = (kind == K_READ);
               ld_ir     = (kind == K_FETCH);
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end else if (cnt == CNT_MAX) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_seq.sv
module tb_mem_access_seq;

   logic       clk;
   logic       rst_n;
   logic       req;
   logic [1:0] req_kind;
   logic       mem_ready;
   logic       busy, done, err, ld_mar, oe_mar, ld_mdr, oe_mdr, ld_ir, mem_rd, mem_wr;

   int tests = 0;
   int fails = 0;

   mem_access_seq #(.WAIT_MAX(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_kind  (req_kind),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .ld_mar    (ld_mar),
      .oe_mar    (oe_mar),
      .ld_mdr    (ld_mdr),
      .oe_mdr    (oe_mdr),
      .ld_ir     (ld_ir),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector bit order:
   // busy done err ld_mar oe_mar ld_mdr oe_mdr ld_ir mem_rd mem_wr
   localparam logic [9:0] O_NONE  = 10'b0000000000;
   localparam logic [9:0] O_LDMAR = 10'b0001000000;
   localparam logic [9:0] O_DONE  = 10'b0100000000;
   localparam logic [9:0] O_DONEA = 10'b0101000000; // done + accepted req
   localparam logic [9:0] O_ERR   = 10'b0010000000;
   localparam logic [9:0] O_RDW   = 10'b1000100010; // read ACCESS, waiting
   localparam logic [9:0] O_RDOK  = 10'b1000110010; // read ACCESS, ready -> ld_mdr
   localparam logic [9:0] O_FTOK  = 10'b1000100110; // fetch ACCESS, ready -> ld_ir
   localparam logic [9:0] O_WDATA = 10'b1000010000;
   localparam logic [9:0] O_WACC  = 10'b1000101001; // write ACCESS (ready or not)

   typedef struct {
      string      name;
      logic       req;
      logic [1:0] kind;
      logic       rdy;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [9:0] outs();
      return {busy, done, err, ld_mar, oe_mar, ld_mdr, oe_mdr, ld_ir, mem_rd, mem_wr};
   endfunction

   task automatic add(input string n, input logic r, input logic [1:0] k,
                      input logic m, input logic [9:0] e);
      vec_t v;
      v.name = n; v.req = r; v.kind = k; v.rdy = m; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string n, input logic [9:0] act, input logic [9:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", n, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] k, input logic m);
      req = r; req_kind = k; mem_ready = m;
   endtask

   initial begin
      // ---- vector table ----
      // read, zero wait states
      add("rd0_req",   1, 2'b00, 0, O_LDMAR);
      add("rd0_acc",   0, 2'b00, 1, O_RDOK);
      add("rd0_done",  0, 2'b00, 0, O_DONE);
      add("idle",      0, 2'b00, 0, O_NONE);
      // write, 3 wait states
      add("wr3_req",   1, 2'b01, 0, O_LDMAR);
      add("wr3_wdata", 0, 2'b00, 0, O_WDATA);
      add("wr3_w1",    0, 2'b00, 0, O_WACC);
      add("wr3_w2",    0, 2'b00, 0, O_WACC);
      add("wr3_w3",    0, 2'b00, 0, O_WACC);
      add("wr3_rdy",   0, 2'b00, 1, O_WACC);
      add("wr3_done",  0, 2'b00, 0, O_DONE);
      // fetch, zero wait states
      add("ft_req",    1, 2'b10, 0, O_LDMAR);
      add("ft_acc",    0, 2'b00, 1, O_FTOK);
      add("ft_done",   0, 2'b00, 0, O_DONE);
      // read timeout: 8 ACCESS cycles then err
      add("to_req",    1, 2'b00, 0, O_LDMAR);
      for (int i = 0; i < 8; i++) add($sformatf("to_acc%0d", i), 0, 2'b00, 0, O_RDW);
      add("to_err",    0, 2'b00, 0, O_ERR);
      add("idle",      0, 2'b00, 0, O_NONE);
      // read with ready on the last allowed cycle
      add("lr_req",    1, 2'b00, 0, O_LDMAR);
      for (int i = 0; i < 7; i++) add($sformatf("lr_acc%0d", i), 0, 2'b00, 0, O_RDW);
      add("lr_rdy8",   0, 2'b00, 1, O_RDOK);
      add("lr_done",   0, 2'b00, 0, O_DONE);
      // reserved kind
      add("rsv_req",   1, 2'b11, 0, O_NONE);
      add("rsv_err",   0, 2'b00, 0, O_ERR);
      // req while busy is ignored; back-to-back req in done cycle accepted
      add("bz_req",    1, 2'b00, 0, O_LDMAR);
      add("bz_ign1",   1, 2'b01, 0, O_RDW);
      add("bz_ign2",   1, 2'b00, 1, O_RDOK);
      add("bb_req",    1, 2'b10, 0, O_DONEA);
      add("bb_acc",    0, 2'b00, 1, O_FTOK);
      add("bb_done",   0, 2'b00, 0, O_DONE);
      add("idle",      0, 2'b00, 0, O_NONE);

      // ---- reset ----
      rst_n = 1'b0;
      drive(0, 2'b00, 0);
      repeat (2) @(negedge clk);
      #1 check("reset_outs", outs(), O_NONE);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- table loop ----
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].req, vecs[i].kind, vecs[i].rdy);
         #1 check(vecs[i].name, outs(), vecs[i].exp);
      end

      // ---- async reset mid-ACCESS ----
      @(negedge clk);
      drive(1, 2'b00, 0);
      #1 check("ar_req", outs(), O_LDMAR);
      @(negedge clk);
      drive(0, 2'b00, 0);
      #1 check("ar_acc", outs(), O_RDW);
      #2 rst_n = 1'b0;
      #1 check("ar_drop", outs(), O_NONE);
      @(negedge clk);
      #1 check("ar_held", outs(), O_NONE);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 check($sformatf("ar_quiet%0d", i), outs(), O_NONE);
      end
      @(negedge clk);
      drive(1, 2'b00, 0);
      #1 check("ar_rd_req", outs(), O_LDMAR);
      @(negedge clk);
      drive(0, 2'b00, 1);
      #1 check("ar_rd_acc", outs(), O_RDOK);
      @(negedge clk);
      drive(0, 2'b00, 0);
      #1 check("ar_rd_done", outs(), O_DONE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
